// File: rtl/ps2_key_ctrl_pkg.sv
// Shared types and PS/2 byte constants for the key-event sequencer.
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_BRK     = 3'd1,
    ST_EXT     = 3'd2,
    ST_EXT_BRK = 3'd3,
    ST_LOOKUP  = 3'd4,
    ST_EMIT    = 3'd5
  } state_t;

  localparam logic [7:0] PS2_BREAK = 8'hF0;
  localparam logic [7:0] PS2_EXT   = 8'hE0;
  localparam logic [7:0] PS2_ACK   = 8'hFA;
  localparam logic [7:0] PS2_BAT   = 8'hAA;

  // Keyboard status/noise bytes that carry no key information when seen outside a sequence.
  function automatic logic is_noise(input logic [7:0] b);
    return (b == PS2_ACK) || (b == PS2_BAT) || (b == 8'h00) || (b == 8'hFF);
  endfunction

endpackage

// File: rtl/ps2_key_ctrl_if.sv
// Scan-byte input, ASCII lookup pair and key-event output of ps2_key_ctrl.
interface ps2_key_ctrl_if #(
  parameter int COUNT_W = 8
);
  logic               in_valid;
  logic [7:0]         in_data;
  logic               in_ready;
  logic [7:0]         lut_scan;
  logic [7:0]         lut_ascii;
  logic               evt_valid;
  logic               evt_ready;
  logic [7:0]         evt_scan;
  logic [7:0]         evt_ascii;
  logic               evt_break;
  logic               evt_ext;
  logic               evt_repeat;
  logic               key_held;
  logic [COUNT_W-1:0] press_cnt;

  modport master (
    input  in_valid, in_data, lut_ascii, evt_ready,
    output in_ready, lut_scan, evt_valid, evt_scan, evt_ascii,
           evt_break, evt_ext, evt_repeat, key_held, press_cnt
  );

  modport slave (
    output in_valid, in_data, lut_ascii, evt_ready,
    input  in_ready, lut_scan, evt_valid, evt_scan, evt_ascii,
           evt_break, evt_ext, evt_repeat, key_held, press_cnt
  );
endinterface

// File: rtl/ps2_key_ctrl_counter.sv
// key_press_counter: wrapping COUNT_W press counter with synchronous clear and increment.
module key_press_counter #(
  parameter int COUNT_W = 8
) (
  input  logic               clk,
  input  logic               i_clr,
  input  logic               i_inc,
  output logic [COUNT_W-1:0] o_cnt
);

  logic [COUNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc) begin
      r_cnt <= r_cnt + {{(COUNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/ps2_key_ctrl.sv
// ps2_key_ctrl: turns make / F0 break / E0 extended scan sequences into one key event each.
// Define PS2_KEY_CTRL_EXT_EN to build the E0 (extended key) path; otherwise E0 is discarded.
module ps2_key_ctrl
  import ps2_pkg::*;
#(
  parameter int COUNT_W = 8
) (
  input  logic           clk,
  input  logic           rst,
  ps2_key_ctrl_if.master bus
);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [7:0]         r_code;
  logic               r_brk;
  logic               r_ext;
  logic               w_latch;
  logic               w_in_ext;
  logic               w_in_brk;
  logic               w_match;
  logic               w_inc;
  logic [7:0]         r_evt_scan;
  logic [7:0]         r_evt_ascii;
  logic               r_evt_break;
  logic               r_evt_repeat;
  logic [7:0]         r_held_code;
  logic               r_held_ext;
  logic               r_key_held;
  logic [COUNT_W-1:0] w_cnt;
`ifdef PS2_KEY_CTRL_EXT_EN
  logic               r_evt_ext;

  assign w_in_ext = (r_state == ST_EXT) || (r_state == ST_EXT_BRK);
`else
  assign w_in_ext = 1'b0;
`endif
  assign w_in_brk = (r_state == ST_BRK) || (r_state == ST_EXT_BRK);

  always_comb begin
    w_state_nxt   = r_state;
    w_latch       = 1'b0;
    bus.in_ready  = 1'b0;
    bus.evt_valid = 1'b0;
    case (r_state)
      ST_IDLE, ST_BRK, ST_EXT, ST_EXT_BRK: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          if (bus.in_data == PS2_BREAK) begin
            w_state_nxt = w_in_ext ? ST_EXT_BRK : ST_BRK;
          end else if (bus.in_data == PS2_EXT) begin
`ifdef PS2_KEY_CTRL_EXT_EN
            w_state_nxt = ST_EXT;
`else
            w_state_nxt = ST_IDLE;
`endif
          end else if ((r_state == ST_IDLE) && is_noise(bus.in_data)) begin
            w_state_nxt = ST_IDLE;
          end else begin
            w_latch     = 1'b1;
            w_state_nxt = ST_LOOKUP;
          end
        end
      end
      ST_LOOKUP: w_state_nxt = ST_EMIT;
      ST_EMIT: begin
        bus.evt_valid = 1'b1;
        if (bus.evt_ready) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // A make of the key already held is a typematic repeat and must not count as a press.
  assign w_match = r_key_held && (r_held_ext == r_ext) && (r_held_code == r_code);
  assign w_inc   = (r_state == ST_LOOKUP) && !r_brk && !w_match;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_code       <= 8'h00;
      r_brk        <= 1'b0;
      r_ext        <= 1'b0;
      r_evt_scan   <= 8'h00;
      r_evt_ascii  <= 8'h00;
      r_evt_break  <= 1'b0;
      r_evt_repeat <= 1'b0;
      r_held_code  <= 8'h00;
      r_held_ext   <= 1'b0;
      r_key_held   <= 1'b0;
`ifdef PS2_KEY_CTRL_EXT_EN
      r_evt_ext    <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      if (w_latch) begin
        r_code <= bus.in_data;
        r_brk  <= w_in_brk;
        r_ext  <= w_in_ext;
      end
      if (r_state == ST_LOOKUP) begin
        r_evt_scan   <= r_code;
        r_evt_ascii  <= r_ext ? 8'h00 : bus.lut_ascii;
        r_evt_break  <= r_brk;
        r_evt_repeat <= !r_brk && w_match;
`ifdef PS2_KEY_CTRL_EXT_EN
        r_evt_ext    <= r_ext;
`endif
        if (!r_brk && !w_match) begin
          r_held_code <= r_code;
          r_held_ext  <= r_ext;
          r_key_held  <= 1'b1;
        end else if (r_brk && w_match) begin
          r_key_held <= 1'b0;
        end
      end
    end
  end

  key_press_counter #(.COUNT_W(COUNT_W)) u_press_cnt (
    .clk   (clk),
    .i_clr (rst),
    .i_inc (w_inc),
    .o_cnt (w_cnt)
  );

  assign bus.lut_scan   = r_code;
  assign bus.evt_scan   = r_evt_scan;
  assign bus.evt_ascii  = r_evt_ascii;
  assign bus.evt_break  = r_evt_break;
  assign bus.evt_repeat = r_evt_repeat;
  assign bus.key_held   = r_key_held;
  assign bus.press_cnt  = w_cnt;
`ifdef PS2_KEY_CTRL_EXT_EN
  assign bus.evt_ext    = r_evt_ext;
`else
  assign bus.evt_ext    = 1'b0;
`endif

endmodule
